// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: register, MDU and eret hazard stalls, flush control, MDU busy tracking.
// Latency: stall/flush outputs are combinational in the same cycle; MDU and stall counters update on clk rise.
// Backpressure: stall freezes F/D and bubbles E; a Req overrides every hazard and flushes D/E/M/W.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [2:0]  Tuse_rs_D,
  input  logic [2:0]  Tuse_rt_D,
  input  logic        RegWrite_E,
  input  logic [4:0]  A3_E,
  input  logic [2:0]  Tnew_E,
  input  logic        RegWrite_M,
  input  logic [4:0]  A3_M,
  input  logic [2:0]  Tnew_M,
  input  logic        md_use_D,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        eret_D,
  input  logic        mtc0_E,
  input  logic        mtc0_M,
  input  logic        Req,
  output logic        stall,
  output logic        flush_E,
  output logic        flush_all,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic rs_haz, rt_haz, md_haz, eret_haz, any_haz;

  // Operand hazards: a producer in E or M whose result arrives later than the D consumer needs it.
  // Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    rs_haz = (rs_D != 5'd0) &&
             ((RegWrite_E && (A3_E == rs_D) && (Tuse_rs_D < Tnew_E)) ||
              (RegWrite_M && (A3_M == rs_D) && (Tuse_rs_D < Tnew_M)));
    rt_haz = (rt_D != 5'd0) &&
             ((RegWrite_E && (A3_E == rt_D) && (Tuse_rt_D < Tnew_E)) ||
              (RegWrite_M && (A3_M == rt_D) && (Tuse_rt_D < Tnew_M)));
  end

  // MDU and eret hazards, then combine; Req wins and reset forces a clean, non-stalled view.
  always_comb begin
    md_haz    = md_use_D && (md_busy || md_start_E);
    eret_haz  = eret_D && (mtc0_E || mtc0_M);
    any_haz   = rs_haz || rt_haz || md_haz || eret_haz;
    stall     = reset && any_haz && !Req;
    flush_E   = stall;
    flush_all = Req || !reset;
  end

  // State register: MDU FSM, remaining-cycle counter and saturating stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: starts are ignored while busy or when the E instruction is flushed by Req;
  // Req never aborts an operation already counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start_E && !Req) begin
          state_d = BUSY;
          cnt_d   = md_div_E ? DIV_CYCLES : MULT_CYCLES;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  // Outputs derived from registered state.
  always_comb begin
    md_busy   = (state_q == BUSY);
    md_cnt    = cnt_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports rs_D, rt_D  in  5 each  source register numbers of the D-stage instruction.
REQ-004 SHALL have ports Tuse_rs_D, Tuse_rt_D  in  3 each  cycles until the D instruction consumes rs/rt.
REQ-005 SHALL have ports RegWrite_E, A3_E, Tnew_E  in  1/5/3  E-stage write enable, destination, and cycles to result.
REQ-006 SHALL have ports RegWrite_M, A3_M, Tnew_M  in  1/5/3  M-stage equivalents.
REQ-007 SHALL have ports md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have ports md_start_E, md_div_E  in  1/1  E instruction starts the MDU; 1 = divide, 0 = multiply.
REQ-009 SHALL have ports eret_D, mtc0_E, mtc0_M  in  1 each  eret in D; mtc0 in E or M.
REQ-010 SHALL have port Req  in  1  exception/interrupt request taken this cycle.
REQ-011 SHALL have ports stall, flush_E, flush_all  out  1 each  freeze F/D; bubble E; clear D/E/M/W.
REQ-012 SHALL have ports md_busy, md_cnt  out  1/4  MDU busy flag and remaining-cycle count.
REQ-013 SHALL have port stall_cnt  out  16  count of cycles with stall=1.

Function
REQ-014 SHALL compute rs hazard = rs_D!=0 and ((RegWrite_E, A3_E==rs_D, Tuse_rs_D<Tnew_E) or (RegWrite_M, A3_M==rs_D, Tuse_rs_D<Tnew_M)); rt analogous.
REQ-015 SHALL compute MDU hazard = md_use_D and (md_busy or md_start_E).
REQ-016 SHALL compute eret hazard = eret_D and (mtc0_E or mtc0_M).
REQ-017 SHALL drive stall = (rs or rt or MDU or eret hazard) and not Req, combinationally, same cycle.
REQ-018 SHALL drive flush_E = stall; flush_all = Req; Req overrides every hazard.
REQ-019 SHALL run MDU FSM with states IDLE and BUSY; md_busy = (state==BUSY).
REQ-020 SHALL, in IDLE at a posedge with md_start_E=1 and Req=0, go to BUSY with md_cnt=10 if md_div_E else 5.
REQ-021 SHALL, in BUSY, decrement md_cnt by 1 per cycle; on the posedge with md_cnt==1, go to IDLE with md_cnt=0.
REQ-022 SHALL make md_busy high for exactly 5 (mult) or 10 (div) cycles after the start edge.
REQ-023 SHALL ignore md_start_E while in BUSY: no restart, counter unaffected.
REQ-024 SHALL ignore md_start_E when Req=1 on the same edge (the E instruction is being flushed).
REQ-025 SHALL let Req not abort an MDU operation already in BUSY; counting continues.
REQ-026 SHALL increment stall_cnt on each posedge with stall=1, saturating at 0xFFFF (no wrap).
REQ-027 SHALL treat register 0 as never hazarding, regardless of RegWrite/A3.

Reset
REQ-028 SHALL, while reset=0, immediately force state=IDLE, md_busy=0, md_cnt=0, stall_cnt=0.
REQ-029 SHALL, while reset=0, force stall=0, flush_E=0, flush_all=1.
REQ-030 SHALL, on reset assertion mid-MDU operation, abandon the operation; first edge after release starts in IDLE.
REQ-031 SHALL, on reset release, not alter state until the next rising clk edge.

Verification
REQ-032 Load-use: RegWrite_E=1, A3_E=8, Tnew_E=2, rs_D=8, Tuse_rs_D=0 -> stall=1, flush_E=1; with Tuse_rs_D=2 -> stall=0.
REQ-033 Zero register: rs_D=0, A3_E=0, RegWrite_E=1, Tnew_E=3, Tuse_rs_D=0 -> stall=0.
REQ-034 Divide: md_start_E=1, md_div_E=1 for 1 cycle, md_use_D=1 held -> md_cnt 10..1, md_busy=1 for 10 cycles, stall=1 from start cycle through last busy cycle, stall_cnt=11.
REQ-035 Req precedence: md_start_E=1, Req=1 same edge -> md_busy stays 0, stall=0, flush_all=1; Req during BUSY with md_cnt=4 -> md_cnt=3 next cycle.
REQ-036 Async reset: md_cnt=7 in BUSY, reset driven 0 between edges -> md_busy=0, md_cnt=0, stall_cnt=0 before next edge; flush_all=1 while reset=0.
REQ-037 Saturation: stall held 1 for 65540 cycles -> stall_cnt=0xFFFF, never 0x0000.
